// File: rtl/tx_os_generator.sv
// tx_os_generator: Gen1/Gen2 (8b/10b) transmit ordered-set generator.
//
// On an accepted start it emits osCount ordered sets (TS1, TS2 or EIOS) on all
// active lanes, four symbols per lane per clock, with per-lane link/lane/N_FTS/
// rate/training-control fields inserted. A word is only produced on edges
// where txReady is high; the bus holds otherwise.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  one-cycle burst request (ignored while busy)
//   osType                 0=TS1, 1=TS2, 2=EIOS, 3=reserved (rejected)
//   osCount                ordered sets per burst (0 rejected)
//   linkNumber, linkPad    link field value / send PAD instead
//   laneNumberPad          send PAD in the lane field instead of lane index
//   numberOfDetectedLanes  active lane count (0 -> 1, >16 -> 16)
//   nFTS, rateid, trainingControl  TS field values
//   txReady                PIPE TX accepts a word this cycle
//   TxData, TxDataK        16 lanes x 32 bits / 4 K flags, symbol 0 in low byte
//   TxDataValid            per-lane word valid
//   busy, done             burst in progress / pulse with the final word
module tx_os_generator #(
    parameter int unsigned MAXLANES = 16,
    parameter int unsigned Width    = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [1:0]                      osType,
    input  logic [7:0]                      osCount,
    input  logic [7:0]                      linkNumber,
    input  logic                            linkPad,
    input  logic                            laneNumberPad,
    input  logic [4:0]                      numberOfDetectedLanes,
    input  logic [7:0]                      nFTS,
    input  logic [7:0]                      rateid,
    input  logic [7:0]                      trainingControl,
    input  logic                            txReady,
    output logic [MAXLANES*Width-1:0]       TxData,
    output logic [MAXLANES*(Width/8)-1:0]   TxDataK,
    output logic [MAXLANES-1:0]             TxDataValid,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned SymPerLane = Width / 8;

    localparam logic [1:0] OsTs1  = 2'd0;
    localparam logic [1:0] OsTs2  = 2'd1;
    localparam logic [1:0] OsEios = 2'd2;
    localparam logic [1:0] OsRsvd = 2'd3;

    localparam logic [7:0] SymCom = 8'hBC;  // K28.5
    localparam logic [7:0] SymPad = 8'hF7;  // K23.7
    localparam logic [7:0] SymIdl = 8'h7C;  // K28.3
    localparam logic [7:0] IdTs1  = 8'h4A;
    localparam logic [7:0] IdTs2  = 8'h45;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e state_q, state_d;

    // Fields latched at burst acceptance.
    logic [1:0] os_type_q, os_type_d;
    logic [7:0] link_q, link_d;
    logic       link_pad_q, link_pad_d;
    logic       lane_pad_q, lane_pad_d;
    logic [4:0] lane_cnt_q, lane_cnt_d;
    logic [7:0] nfts_q, nfts_d;
    logic [7:0] rateid_q, rateid_d;
    logic [7:0] tc_q, tc_d;

    logic [1:0] idx_q, idx_d;
    logic [7:0] rem_q, rem_d;

    logic [MAXLANES*Width-1:0]      tx_data_q, tx_data_d;
    logic [MAXLANES*SymPerLane-1:0] tx_k_q, tx_k_d;
    logic [MAXLANES-1:0]            tx_valid_q, tx_valid_d;
    logic                           done_q, done_d;

    logic                  accept;
    logic [1:0]            last_idx;
    logic                  is_last;
    logic [4:0]            lanes_clamped;
    logic [Width-1:0]      tmpl_data;
    logic [SymPerLane-1:0] tmpl_k;
    logic                  lane_field_idx;
    logic [Width-1:0]      lane_word;
    logic [7:0]            ts_id;

    assign accept   = (state_q == StIdle) && start && (osCount != 8'd0) && (osType != OsRsvd);
    assign last_idx = (os_type_q == OsEios) ? 2'd0 : 2'd3;
    assign is_last  = (idx_q == last_idx) && (rem_q == 8'd1);
    assign ts_id    = (os_type_q == OsTs2) ? IdTs2 : IdTs1;

    always_comb begin
        if (numberOfDetectedLanes == 5'd0) begin
            lanes_clamped = 5'd1;
        end else if (numberOfDetectedLanes > 5'(MAXLANES)) begin
            lanes_clamped = 5'(MAXLANES);
        end else begin
            lanes_clamped = numberOfDetectedLanes;
        end
    end

    // Word template shared by all lanes; only the lane field differs per lane.
    always_comb begin
        tmpl_data      = '0;
        tmpl_k         = '0;
        lane_field_idx = 1'b0;
        if (os_type_q == OsEios) begin
            tmpl_data = {SymIdl, SymIdl, SymIdl, SymCom};
            tmpl_k    = 4'hF;
        end else begin
            unique case (idx_q)
                2'd0: begin
                    tmpl_data      = {nfts_q, (lane_pad_q ? SymPad : 8'h00),
                                      (link_pad_q ? SymPad : link_q), SymCom};
                    tmpl_k         = {1'b0, lane_pad_q, link_pad_q, 1'b1};
                    lane_field_idx = !lane_pad_q;
                end
                2'd1: tmpl_data = {ts_id, ts_id, tc_q, rateid_q};
                default: tmpl_data = {ts_id, ts_id, ts_id, ts_id};
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            os_type_q  <= OsTs1;
            link_q     <= '0;
            link_pad_q <= 1'b0;
            lane_pad_q <= 1'b0;
            lane_cnt_q <= '0;
            nfts_q     <= '0;
            rateid_q   <= '0;
            tc_q       <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            tx_data_q  <= '0;
            tx_k_q     <= '0;
            tx_valid_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            os_type_q  <= os_type_d;
            link_q     <= link_d;
            link_pad_q <= link_pad_d;
            lane_pad_q <= lane_pad_d;
            lane_cnt_q <= lane_cnt_d;
            nfts_q     <= nfts_d;
            rateid_q   <= rateid_d;
            tc_q       <= tc_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            tx_data_q  <= tx_data_d;
            tx_k_q     <= tx_k_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StSend;
            StSend: if (txReady && is_last) state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic.
    always_comb begin
        os_type_d  = os_type_q;
        link_d     = link_q;
        link_pad_d = link_pad_q;
        lane_pad_d = lane_pad_q;
        lane_cnt_d = lane_cnt_q;
        nfts_d     = nfts_q;
        rateid_d   = rateid_q;
        tc_d       = tc_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        tx_data_d  = tx_data_q;  // data and K hold when no word is sent
        tx_k_d     = tx_k_q;
        tx_valid_d = '0;
        done_d     = 1'b0;
        lane_word  = '0;

        if (accept) begin
            os_type_d  = osType;
            link_d     = linkNumber;
            link_pad_d = linkPad;
            lane_pad_d = laneNumberPad;
            lane_cnt_d = lanes_clamped;
            nfts_d     = nFTS;
            rateid_d   = rateid;
            tc_d       = trainingControl;
            idx_d      = 2'd0;
            rem_d      = osCount;
        end

        if ((state_q == StSend) && txReady) begin
            for (int i = 0; i < int'(MAXLANES); i++) begin
                lane_word = tmpl_data;
                if (lane_field_idx) lane_word[23:16] = 8'(i);
                if (i < int'(lane_cnt_q)) begin
                    tx_data_d[i*Width +: Width]           = lane_word;
                    tx_k_d[i*SymPerLane +: SymPerLane]    = tmpl_k;
                    tx_valid_d[i]                         = 1'b1;
                end else begin
                    tx_data_d[i*Width +: Width]           = '0;
                    tx_k_d[i*SymPerLane +: SymPerLane]    = '0;
                end
            end
            if (idx_q == last_idx) begin
                idx_d = 2'd0;
                rem_d = rem_q - 8'd1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
            done_d = is_last;
        end
    end

    assign TxData      = tx_data_q;
    assign TxDataK     = tx_k_q;
    assign TxDataValid = tx_valid_q;
    assign busy        = (state_q == StSend);
    assign done        = done_q;

endmodule

// File: tb/tb_tx_os_generator.sv
// Testbench for tx_os_generator: directed scenarios plus randomized traffic
// checked every cycle against a queue-of-words reference model.
module tb_tx_os_generator;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   osType;
    logic [7:0]   osCount;
    logic [7:0]   linkNumber;
    logic         linkPad;
    logic         laneNumberPad;
    logic [4:0]   numberOfDetectedLanes;
    logic [7:0]   nFTS;
    logic [7:0]   rateid;
    logic [7:0]   trainingControl;
    logic         txReady;
    logic [511:0] TxData;
    logic [63:0]  TxDataK;
    logic [15:0]  TxDataValid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    tx_os_generator #(
        .MAXLANES (16),
        .Width    (32)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .osType                (osType),
        .osCount               (osCount),
        .linkNumber            (linkNumber),
        .linkPad               (linkPad),
        .laneNumberPad         (laneNumberPad),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .nFTS                  (nFTS),
        .rateid                (rateid),
        .trainingControl       (trainingControl),
        .txReady               (txReady),
        .TxData                (TxData),
        .TxDataK               (TxDataK),
        .TxDataValid           (TxDataValid),
        .busy                  (busy),
        .done                  (done)
    );

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic [15:0]  v;
    } word_t;

    word_t        q[$];
    logic [511:0] exp_d;
    logic [63:0]  exp_k;
    logic [15:0]  exp_v;
    logic         exp_done;
    logic         exp_busy;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Symbol at position pos of the ordered set for a given lane.
    function automatic void os_sym(input int lane, input int pos,
                                   output logic [7:0] s, output logic k);
        logic [7:0] id;
        id = (osType == 2'd1) ? 8'h45 : 8'h4A;
        if (osType == 2'd2) begin
            s = (pos == 0) ? 8'hBC : 8'h7C;
            k = 1'b1;
        end else begin
            k = 1'b0;
            case (pos)
                0: begin s = 8'hBC; k = 1'b1; end
                1: begin s = linkPad ? 8'hF7 : linkNumber; k = linkPad; end
                2: begin s = laneNumberPad ? 8'hF7 : 8'(lane); k = laneNumberPad; end
                3: s = nFTS;
                4: s = rateid;
                5: s = trainingControl;
                default: s = id;
            endcase
        end
    endfunction

    task automatic model_accept();
        int    nl;
        int    nw;
        word_t e;
        logic [7:0] s;
        logic       k;
        nl = (numberOfDetectedLanes == 0) ? 1 :
             (numberOfDetectedLanes > 16) ? 16 : int'(numberOfDetectedLanes);
        nw = (osType == 2'd2) ? 1 : 4;
        for (int r = 0; r < int'(osCount); r++) begin
            for (int w = 0; w < nw; w++) begin
                e.d = '0; e.k = '0; e.v = '0;
                for (int l = 0; l < nl; l++) begin
                    e.v[l] = 1'b1;
                    for (int p = 0; p < 4; p++) begin
                        os_sym(l, 4*w + p, s, k);
                        e.d[l*32 + p*8 +: 8] = s;
                        e.k[l*4 + p]         = k;
                    end
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic model_step();
        word_t e;
        if (reset) begin
            q.delete();
            exp_d = '0; exp_k = '0; exp_v = '0; exp_done = 1'b0;
        end else if (q.size() != 0) begin
            if (txReady) begin
                e = q.pop_front();
                exp_d = e.d; exp_k = e.k; exp_v = e.v;
                exp_done = (q.size() == 0);
            end else begin
                exp_v = '0; exp_done = 1'b0;
            end
        end else begin
            exp_v = '0; exp_done = 1'b0;
            if (start && osCount != 0 && osType != 2'd3) model_accept();
        end
        exp_busy = (q.size() != 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_eq("TxData", TxData, exp_d);
        check_eq("TxDataK", TxDataK, exp_k);
        check_eq("TxDataValid", TxDataValid, exp_v);
        check_eq("busy", busy, exp_busy);
        check_eq("done", done, exp_done);
    endtask

    task automatic set_s1();
        osType = 2'd0; osCount = 8'd1; numberOfDetectedLanes = 5'd2;
        linkNumber = 8'h01; linkPad = 1'b0; laneNumberPad = 1'b0;
        nFTS = 8'h20; rateid = 8'h02; trainingControl = 8'h00; txReady = 1'b1;
    endtask

    task automatic scn1();
        set_s1(); start = 1'b1;
        step(); start = 1'b0;
        check_eq("s1_busy", busy, 1);
        step();
        check_eq("s1_w0_l0", TxData[31:0], 32'h200001BC);
        check_eq("s1_w0_l1", TxData[63:32], 32'h200101BC);
        check_eq("s1_w0_k", TxDataK[7:0], 8'h11);
        check_eq("s1_valid", TxDataValid, 16'h0003);
        check_eq("s1_w0_done", done, 0);
        step();
        check_eq("s1_w1", TxData[31:0], 32'h4A4A0002);
        check_eq("s1_w1_k", TxDataK[7:0], 8'h00);
        step();
        step();
        check_eq("s1_w3", TxData[63:32], 32'h4A4A4A4A);
        check_eq("s1_w3_done", done, 1);
        check_eq("s1_hi_lanes", TxData[511:64], 0);
        check_eq("s1_w3_busy", busy, 0);
        step();
        check_eq("s1_after_valid", TxDataValid, 0);
        check_eq("s1_after_done", done, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; txReady = 1'b0;
        set_s1();
        step(); step();
        check_eq("rst_data", TxData, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;

        scn1();

        // Reset while word2 is on the bus, then scenario 1 again.
        start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        check_eq("s6_w2", TxData[31:0], 32'h4A4A4A4A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("s6_rst_valid", TxDataValid, 0);
        check_eq("s6_rst_data", TxData, 0);
        check_eq("s6_rst_done", done, 0);
        scn1();

        // EIOS on all 16 lanes.
        osType = 2'd2; osCount = 8'd1; numberOfDetectedLanes = 5'd16; start = 1'b1;
        step(); start = 1'b0;
        step();
        check_eq("eios_l15", TxData[511:480], 32'h7C7C7CBC);
        check_eq("eios_k", TxDataK, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("eios_valid", TxDataValid, 16'hFFFF);
        check_eq("eios_done", done, 1);
        check_eq("eios_busy", busy, 0);
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset           = ($urandom_range(0, 99) == 0);
            start           = ($urandom_range(0, 3) == 0);
            osType          = 2'($urandom_range(0, 3));
            osCount         = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            numberOfDetectedLanes = 5'($urandom_range(0, 31));
            linkNumber      = 8'($urandom);
            linkPad         = 1'($urandom);
            laneNumberPad   = 1'($urandom);
            nFTS            = 8'($urandom);
            rateid          = 8'($urandom);
            trainingControl = 8'($urandom);
            txReady         = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
